// File: rtl/sifre_cozme_birimi.sv
// sifre_cozme_birimi
// Multi-cycle decode unit that undoes the reversible operations of
// sifreleme_birimi: bit reversal, un-packing of a PKG word, and the inverse of
// shift-left-add ((deger1 - deger2) >> 1).
// Serial operations are processed ADIM_GENISLIGI bits per cycle, so a serial
// operation takes L = 32/ADIM_GENISLIGI cycles. Direct operations finish on
// the acceptance edge.
// Requests and results both use valid/ready handshakes. Every output is driven
// straight from a flop.
// Optional feature: define COZME_HATA_DENETIM_EN to enable the hata_o error
// flag. When it is not defined, hata_o is tied low and the error logic is
// removed.

module sifre_cozme_birimi #(
    parameter int ADIM_GENISLIGI = 4   // legal values: 1, 2, 4, 8, 16, 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        istek_gecerli_i,
    output logic        istek_hazir_o,
    input  logic [2:0]  kontrol_i,
    input  logic [31:0] deger1_i,
    input  logic [31:0] deger2_i,
    output logic        sonuc_gecerli_o,
    input  logic        sonuc_hazir_i,
    output logic [31:0] sonuc_o,
    output logic        hata_o
);

    // Number of ISLE cycles needed for one serial operation.
    localparam int L       = 32 / ADIM_GENISLIGI;
    localparam int SAYAC_W = 6;
    localparam logic [SAYAC_W-1:0] SON_SAYAC = SAYAC_W'(L - 1);

    // Operation codes. These are shared with the encoder side.
    localparam logic [2:0] COZME_RVRS      = 3'd0;
    localparam logic [2:0] COZME_UNPKG_ALT = 3'd1;
    localparam logic [2:0] COZME_UNPKG_UST = 3'd2;
    localparam logic [2:0] COZME_SLSUB     = 3'd3;

    typedef enum logic [1:0] {
        BOS   = 2'd0,   // idle, waiting for a request
        ISLE  = 2'd1,   // serial datapath is running
        SONUC = 2'd2    // result is presented, waiting for the consumer
    } durum_t;

    durum_t r_durum;
    durum_t w_sonraki_durum;

    // Operands and code latched when a request is accepted
    logic [2:0]  r_kontrol;
    logic [31:0] r_deger1;
    logic [31:0] r_deger2;

    // Serial datapath state
    logic [31:0]        r_calisma;    // partial result assembled chunk by chunk
    logic [SAYAC_W-1:0] r_sayac;      // index of the chunk handled this cycle
    logic               r_borc;       // borrow carried between SLSUB chunks

    // Registered outputs
    logic [31:0] r_sonuc;
    logic        r_istek_hazir;
    logic        r_sonuc_gecerli;

    // Combinational helpers
    logic                      w_kabul;
    logic                      w_seri_kod;
    logic                      w_son_parca;
    logic [4:0]                w_kaynak_idx;
    logic [4:0]                w_hedef_idx;
    logic [ADIM_GENISLIGI-1:0] w_a_parca;
    logic [ADIM_GENISLIGI-1:0] w_b_parca;
    logic [ADIM_GENISLIGI-1:0] w_ters_parca;
    logic [ADIM_GENISLIGI:0]   w_fark;
    logic [31:0]               w_sonraki_calisma;
    logic [31:0]               w_seri_sonuc;
    logic [31:0]               w_direkt_sonuc;

    // A request is taken only in BOS. Requests that arrive in any other state
    // are ignored, because there is no queue.
    assign w_kabul     = istek_gecerli_i && (r_durum == BOS);
    assign w_seri_kod  = (kontrol_i == COZME_RVRS) || (kontrol_i == COZME_SLSUB);
    assign w_son_parca = (r_sayac == SON_SAYAC);

    // Next-state logic for the BOS -> ISLE/SONUC -> BOS handshake sequence
    always_comb begin
        // NOTE: assign a default first so that every path drives the signal;
        // a path that left it unassigned would infer a latch.
        w_sonraki_durum = r_durum;
        case (r_durum)
            BOS: begin
                if (istek_gecerli_i) begin
                    w_sonraki_durum = w_seri_kod ? ISLE : SONUC;
                end
            end
            ISLE: begin
                if (w_son_parca) begin
                    w_sonraki_durum = SONUC;
                end
            end
            SONUC: begin
                if (sonuc_hazir_i) begin
                    w_sonraki_durum = BOS;
                end
            end
            default: w_sonraki_durum = BOS;
        endcase
    end

    // State register. A synchronous reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is always written with non-blocking '<=' so
        // that every flop samples values from before the edge, whatever the
        // statement order.
        if (rst_i) begin
            r_durum <= BOS;
        end else begin
            r_durum <= w_sonraki_durum;
        end
    end

    // Handshake flags are registered from the next state, so they never
    // depend combinationally on the inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_istek_hazir   <= 1'b1;
            r_sonuc_gecerli <= 1'b0;
        end else begin
            r_istek_hazir   <= (w_sonraki_durum == BOS);
            r_sonuc_gecerli <= (w_sonraki_durum == SONUC);
        end
    end

    // Capture the operands and code on acceptance; build the partial result
    // while in ISLE.
    always_ff @(posedge clk_i) begin
        // NOTE: these pure data registers have no reset. Each one is written
        // before it is read on every path, so clearing them would cost reset
        // routing and buy nothing.
        if (w_kabul) begin
            r_kontrol <= kontrol_i;
            r_deger1  <= deger1_i;
            r_deger2  <= deger2_i;
        end
        if (r_durum == ISLE) begin
            r_calisma <= w_sonraki_calisma;
        end
    end

    // Chunk counter and borrow: both are cleared on acceptance and advanced
    // on each ISLE edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sayac <= '0;
            r_borc  <= 1'b0;
        end else if (w_kabul) begin
            r_sayac <= '0;
            r_borc  <= 1'b0;
        end else if (r_durum == ISLE) begin
            r_sayac <= r_sayac + SAYAC_W'(1);
            r_borc  <= w_fark[ADIM_GENISLIGI];
        end
    end

    // Chunk k of the operands is read from bit k*W upward. For RVRS, that
    // chunk lands at the mirrored position 32-(k+1)*W.
    always_comb begin
        w_kaynak_idx = 5'(int'(r_sayac) * ADIM_GENISLIGI);
        w_hedef_idx  = 5'(32 - (int'(r_sayac) + 1) * ADIM_GENISLIGI);
        w_a_parca    = r_deger1[w_kaynak_idx +: ADIM_GENISLIGI];
        w_b_parca    = r_deger2[w_kaynak_idx +: ADIM_GENISLIGI];
    end

    // Reverse the bit order inside one chunk. The mirrored placement above
    // then completes the full 32-bit reversal.
    always_comb begin
        w_ters_parca = '0;
        for (int i = 0; i < ADIM_GENISLIGI; i++) begin
            w_ters_parca[i] = w_a_parca[ADIM_GENISLIGI-1-i];
        end
    end

    // Ripple-borrow subtraction of one chunk. The top bit of w_fark is the
    // borrow out, because a negative (W+1)-bit difference sets its MSB.
    always_comb begin
        w_fark = {1'b0, w_a_parca} - {1'b0, w_b_parca}
               - {{ADIM_GENISLIGI{1'b0}}, r_borc};
    end

    // Merge this cycle's chunk into the partial result. On the last chunk,
    // also form the final value: SLSUB applies its >>1 here, as the result
    // is loaded into the output register.
    always_comb begin
        w_sonraki_calisma = r_calisma;
        if (r_kontrol == COZME_RVRS) begin
            w_sonraki_calisma[w_hedef_idx +: ADIM_GENISLIGI] = w_ters_parca;
        end else begin
            w_sonraki_calisma[w_kaynak_idx +: ADIM_GENISLIGI] = w_fark[ADIM_GENISLIGI-1:0];
        end
        if (r_kontrol == COZME_SLSUB) begin
            w_seri_sonuc = {1'b0, w_sonraki_calisma[31:1]};
        end else begin
            w_seri_sonuc = w_sonraki_calisma;
        end
    end

    // Direct operations are taken straight from the request operands. Illegal
    // codes decode to zero.
    always_comb begin
        case (kontrol_i)
            COZME_UNPKG_ALT: w_direkt_sonuc = {16'h0000, deger1_i[15:0]};
            COZME_UNPKG_UST: w_direkt_sonuc = {16'h0000, deger1_i[31:16]};
            default:         w_direkt_sonuc = 32'h0000_0000;
        endcase
    end

    // The result register changes only when an operation completes, so the
    // last result stays visible after its handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sonuc <= 32'h0000_0000;
        end else if (w_kabul && !w_seri_kod) begin
            r_sonuc <= w_direkt_sonuc;
        end else if ((r_durum == ISLE) && w_son_parca) begin
            r_sonuc <= w_seri_sonuc;
        end
    end

`ifdef COZME_HATA_DENETIM_EN
    logic r_hata;
    logic w_direkt_hata;
    logic w_seri_hata;

    // An illegal code sets bit 2. For SLSUB, an odd difference or a final
    // borrow means the operands were not a valid shift-left-add output.
    assign w_direkt_hata = kontrol_i[2];
    assign w_seri_hata   = (r_kontrol == COZME_SLSUB)
                         && (w_sonraki_calisma[0] || w_fark[ADIM_GENISLIGI]);

    // The error flag is updated together with the result register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hata <= 1'b0;
        end else if (w_kabul && !w_seri_kod) begin
            r_hata <= w_direkt_hata;
        end else if ((r_durum == ISLE) && w_son_parca) begin
            r_hata <= w_seri_hata;
        end
    end

    assign hata_o = r_hata;
`else
    assign hata_o = 1'b0;
`endif

    assign istek_hazir_o   = r_istek_hazir;
    assign sonuc_gecerli_o = r_sonuc_gecerli;
    assign sonuc_o         = r_sonuc;

endmodule

// File: tb/tb_sifre_cozme_birimi.sv
// Testbench for sifre_cozme_birimi (ADIM_GENISLIGI = 4).
// A stimulus process drives directed requests and pushes each expected result
// into a scoreboard queue. A monitor process pops from the queue and compares
// whenever a result handshake takes place. Timing, backpressure and reset
// behaviour are compared directly in the stimulus process.

module tb_sifre_cozme_birimi;

    localparam int ADIM = 4;
    localparam int L    = 32 / ADIM;

`ifdef COZME_HATA_DENETIM_EN
    localparam logic HATA_EN = 1'b1;
`else
    localparam logic HATA_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        istek_gecerli_i;
    logic        istek_hazir_o;
    logic [2:0]  kontrol_i;
    logic [31:0] deger1_i;
    logic [31:0] deger2_i;
    logic        sonuc_gecerli_o;
    logic        sonuc_hazir_i;
    logic [31:0] sonuc_o;
    logic        hata_o;

    sifre_cozme_birimi #(.ADIM_GENISLIGI(ADIM)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .istek_gecerli_i (istek_gecerli_i),
        .istek_hazir_o   (istek_hazir_o),
        .kontrol_i       (kontrol_i),
        .deger1_i        (deger1_i),
        .deger2_i        (deger2_i),
        .sonuc_gecerli_o (sonuc_gecerli_o),
        .sonuc_hazir_i   (sonuc_hazir_i),
        .sonuc_o         (sonuc_o),
        .hata_o          (hata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] sonuc;
        logic        hata;
        string       ad;
    } beklenen_t;

    beklenen_t sb_q[$];
    int n_test = 0;
    int n_fail = 0;

    task automatic check(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        n_test++;
        if (gercek !== beklenen) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", ad, gercek, beklenen);
        end
    endtask

    task automatic sb_push(input logic [31:0] s, input logic h, input string ad);
        beklenen_t b;
        b.sonuc = s;
        b.hata  = h;
        b.ad    = ad;
        sb_q.push_back(b);
    endtask

    // Monitor: compare against the scoreboard on every result handshake.
    always @(negedge clk_i) begin
        if (!rst_i && sonuc_gecerli_o && sonuc_hazir_i) begin
            if (sb_q.size() == 0) begin
                n_test++;
                n_fail++;
                $display("FAIL sb_unexpected: got result %h, expected no result", sonuc_o);
            end else begin
                beklenen_t b;
                b = sb_q.pop_front();
                check({b.ad, "_sonuc"}, sonuc_o, b.sonuc);
                check({b.ad, "_hata"}, {31'b0, hata_o}, {31'b0, b.hata});
            end
        end
    end

    // Issue one request, push its expected result, and check the number of
    // edges from acceptance to sonuc_gecerli_o. The task returns once the
    // result has been consumed (sonuc_hazir_i is assumed high).
    task automatic istek(input logic [2:0] kod, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] bek_sonuc, input logic bek_hata,
                         input string ad, input int bek_gecikme);
        int bekle;
        int gecikme;
        kontrol_i       = kod;
        deger1_i        = d1;
        deger2_i        = d2;
        istek_gecerli_i = 1'b1;
        bekle = 0;
        while (!istek_hazir_o && bekle < 50) begin
            @(posedge clk_i); #1;
            bekle++;
        end
        if (!istek_hazir_o) begin
            n_test++;
            n_fail++;
            $display("FAIL %s_accept: istek_hazir_o got 0, expected 1", ad);
            istek_gecerli_i = 1'b0;
            return;
        end
        sb_push(bek_sonuc, bek_hata, ad);
        @(posedge clk_i); #1;           // acceptance edge E0
        istek_gecerli_i = 1'b0;
        gecikme = 0;
        while (!sonuc_gecerli_o && gecikme < 40) begin
            @(posedge clk_i); #1;
            gecikme++;
        end
        check({ad, "_latency"}, 32'(gecikme), 32'(bek_gecikme));
        bekle = 0;
        while (sonuc_gecerli_o && bekle < 50) begin
            @(posedge clk_i); #1;
            bekle++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int bekle;
        rst_i           = 1'b1;
        istek_gecerli_i = 1'b0;
        kontrol_i       = 3'd0;
        deger1_i        = 32'h0;
        deger2_i        = 32'h0;
        sonuc_hazir_i   = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_istek_hazir", {31'b0, istek_hazir_o}, 32'd1);
        check("reset_sonuc_gecerli", {31'b0, sonuc_gecerli_o}, 32'd0);
        check("reset_sonuc", sonuc_o, 32'h0);
        check("reset_hata", {31'b0, hata_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Serial and direct operations
        istek(3'd0, 32'hffff_0000, 32'h0, 32'h0000_ffff, 1'b0, "rvrs_ffff0000", L);
        istek(3'd0, 32'h1234_5678, 32'h0, 32'h1e6a_2c48, 1'b0, "rvrs_12345678", L);
        istek(3'd3, 32'd70, 32'd38, 32'd16, 1'b0, "slsub_70_38", L);
        istek(3'd3, 32'd71, 32'd38, 32'd16, HATA_EN, "slsub_71_38", L);
        istek(3'd3, 32'd10, 32'd12, 32'h7fff_ffff, HATA_EN, "slsub_10_12", L);
        istek(3'd3, 32'h0001_0000, 32'd1, 32'h0000_7fff, HATA_EN, "slsub_borrow", L);
        istek(3'd1, 32'h0f0f_000f, 32'h0, 32'h0000_000f, 1'b0, "unpkg_alt", 0);
        istek(3'd2, 32'h0f0f_000f, 32'h0, 32'h0000_0f0f, 1'b0, "unpkg_ust", 0);
        istek(3'd7, 32'hdead_beef, 32'h0, 32'h0, HATA_EN, "illegal_7", 0);

        // Backpressure: hold the result while a second request is pending
        sonuc_hazir_i   = 1'b0;
        kontrol_i       = 3'd0;
        deger1_i        = 32'h0000_00f0;
        deger2_i        = 32'h0;
        istek_gecerli_i = 1'b1;
        sb_push(32'h0f00_0000, 1'b0, "bp_rvrs");
        @(posedge clk_i); #1;           // RVRS accepted
        kontrol_i = 3'd2;               // second request, held valid from now on
        deger1_i  = 32'habcd_1234;
        check("bp_busy_hazir", {31'b0, istek_hazir_o}, 32'd0);
        bekle = 0;
        while (!sonuc_gecerli_o && bekle < 40) begin
            @(posedge clk_i); #1;
            bekle++;
        end
        check("bp_rvrs_latency", 32'(bekle), 32'(L));
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_sonuc", sonuc_o, 32'h0f00_0000);
            check("bp_hold_hazir", {31'b0, istek_hazir_o}, 32'd0);
            check("bp_hold_gecerli", {31'b0, sonuc_gecerli_o}, 32'd1);
            @(posedge clk_i); #1;
        end
        sonuc_hazir_i = 1'b1;
        sb_push(32'h0000_abcd, 1'b0, "bp_ust");
        @(posedge clk_i); #1;           // ER: result handshake
        check("bp_er_hazir", {31'b0, istek_hazir_o}, 32'd1);
        check("bp_er_gecerli", {31'b0, sonuc_gecerli_o}, 32'd0);
        @(posedge clk_i); #1;           // ER+1: second request accepted
        istek_gecerli_i = 1'b0;
        check("bp_er1_hazir", {31'b0, istek_hazir_o}, 32'd0);
        check("bp_er1_gecerli", {31'b0, sonuc_gecerli_o}, 32'd1);
        @(posedge clk_i); #1;           // second result consumed

        // Reset on the third ISLE edge of an SLSUB
        kontrol_i       = 3'd3;
        deger1_i        = 32'd70;
        deger2_i        = 32'd38;
        istek_gecerli_i = 1'b1;
        @(posedge clk_i); #1;           // E0
        istek_gecerli_i = 1'b0;
        @(posedge clk_i); #1;           // E1
        @(posedge clk_i); #1;           // E2
        rst_i = 1'b1;
        @(posedge clk_i); #1;           // E3: reset edge
        check("rst_mid_hazir", {31'b0, istek_hazir_o}, 32'd1);
        check("rst_mid_gecerli", {31'b0, sonuc_gecerli_o}, 32'd0);
        check("rst_mid_sonuc", sonuc_o, 32'h0);
        check("rst_mid_hata", {31'b0, hata_o}, 32'd0);
        rst_i = 1'b0;
        istek(3'd0, 32'h0000_0001, 32'h0, 32'h8000_0000, 1'b0, "rst_rvrs", L);

        repeat (3) @(posedge clk_i);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
